// File: rtl/riscv_pkg.sv
// Shared RV32I definitions for the fetch/decode register slice.
//   - Base-set opcode values, load funct3 codes and the reset NOP instruction.
//   - opcode_illegal(): flags any opcode outside the RV32I base set.
package riscv_pkg;

  localparam logic [6:0] OP_LOAD   = 7'h03;
  localparam logic [6:0] OP_IMM    = 7'h13;
  localparam logic [6:0] OP_AUIPC  = 7'h17;
  localparam logic [6:0] OP_STORE  = 7'h23;
  localparam logic [6:0] OP_R      = 7'h33;
  localparam logic [6:0] OP_LUI    = 7'h37;
  localparam logic [6:0] OP_BRANCH = 7'h63;
  localparam logic [6:0] OP_JALR   = 7'h67;
  localparam logic [6:0] OP_JAL    = 7'h6F;
  localparam logic [6:0] OP_SYSTEM = 7'h73;

  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;

  // addi x0, x0, 0
  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

  function automatic logic opcode_illegal(logic [6:0] op);
    logic legal;
    legal = 1'b0;
    // Every 32-bit encoding has op[1:0] == 2'b11; anything else is compressed or reserved.
    if (op[1:0] == 2'b11) begin
      case (op)
        OP_LOAD, OP_IMM, OP_AUIPC, OP_STORE, OP_R,
        OP_LUI, OP_BRANCH, OP_JALR, OP_JAL, OP_SYSTEM: legal = 1'b1;
        default:                                       legal = 1'b0;
      endcase
    end
    return !legal;
  endfunction

endpackage

// File: rtl/fetch_decode_regs_if.sv
// Bus between the multicycle control/datapath and the fetch/decode register slice.
//   master: drives PC_Write, Ir_Write, PC_Next, Read_Data, Adr_Lo; observes state.
//   slave : the register slice; drives PC, Old_PC, Instr, decoded fields, Load_Data,
//           Illegal, Misaligned, Cycle_Cnt, Instret_Cnt.
interface fetch_decode_regs_if;

  logic        PC_Write;
  logic        Ir_Write;
  logic [31:0] PC_Next;
  logic [31:0] Read_Data;
  logic [1:0]  Adr_Lo;

  logic [31:0] PC;
  logic [31:0] Old_PC;
  logic [31:0] Instr;
  logic [6:0]  op;
  logic [2:0]  Funct3;
  logic        Funct7b5;
  logic [4:0]  Rs1;
  logic [4:0]  Rs2;
  logic [4:0]  Rd;
  logic [31:0] Load_Data;
  logic        Illegal;
  logic        Misaligned;
  logic [63:0] Cycle_Cnt;
  logic [63:0] Instret_Cnt;

  modport master (
    output PC_Write, Ir_Write, PC_Next, Read_Data, Adr_Lo,
    input  PC, Old_PC, Instr, op, Funct3, Funct7b5, Rs1, Rs2, Rd,
           Load_Data, Illegal, Misaligned, Cycle_Cnt, Instret_Cnt
  );

  modport slave (
    input  PC_Write, Ir_Write, PC_Next, Read_Data, Adr_Lo,
    output PC, Old_PC, Instr, op, Funct3, Funct7b5, Rs1, Rs2, Rd,
           Load_Data, Illegal, Misaligned, Cycle_Cnt, Instret_Cnt
  );

endinterface

// File: rtl/load_extend.sv
// Load result extension from the memory-data register.
//   data_i      : registered memory word
//   adr_i       : registered byte offset of the access
//   funct3_i    : load type from the instruction register
//   load_data_o : byte/half selected and sign- or zero-extended; word otherwise
module load_extend
  import riscv_pkg::*;
(
  input  logic [31:0] data_i,
  input  logic [1:0]  adr_i,
  input  logic [2:0]  funct3_i,
  output logic [31:0] load_data_o
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  always_comb begin
    byte_sel = data_i[7:0];
    case (adr_i)
      2'd0:    byte_sel = data_i[7:0];
      2'd1:    byte_sel = data_i[15:8];
      2'd2:    byte_sel = data_i[23:16];
      default: byte_sel = data_i[31:24];
    endcase
    // Halfword alignment only looks at the upper offset bit.
    half_sel = adr_i[1] ? data_i[31:16] : data_i[15:0];

    case (funct3_i)
      F3_LB:   load_data_o = {{24{byte_sel[7]}}, byte_sel};
      F3_LH:   load_data_o = {{16{half_sel[15]}}, half_sel};
      F3_LW:   load_data_o = data_i;
      F3_LBU:  load_data_o = {24'd0, byte_sel};
      F3_LHU:  load_data_o = {16'd0, half_sel};
      default: load_data_o = data_i;
    endcase
  end

endmodule

// File: rtl/fetch_decode_regs.sv
// Architectural state registers feeding the multicycle RV32I control unit.
//   clk   : core clock, all state on rising edge
//   reset : asynchronous, active-low
//   bus   : fetch_decode_regs_if.slave (strobes, next PC, read data in; PC, OldPC, IR,
//           decoded fields, extended load data, Illegal/Misaligned flags, counters out)
// Optional feature: define PERF_CNT_EN to build the 64-bit cycle and instret counters;
// otherwise Cycle_Cnt and Instret_Cnt are tied to zero.
// Only XLEN = 32 is supported.
module fetch_decode_regs #(
  parameter int unsigned XLEN         = 32,
  parameter logic [31:0] RESET_VECTOR = 32'h0000_0000,
  parameter logic [31:0] NOP_INSTR    = riscv_pkg::NOP_INSTR
) (
  input logic               clk,
  input logic               reset,
  fetch_decode_regs_if.slave bus
);

  import riscv_pkg::*;

  logic [XLEN-1:0] pc_q, old_pc_q, instr_q, data_q;
  logic [1:0]      adr_q;
  logic            illegal_q, misaligned_q;

  // Old_PC samples the pre-edge PC, so a combined fetch edge records the fetched address.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pc_q         <= RESET_VECTOR;
      old_pc_q     <= '0;
      instr_q      <= NOP_INSTR;
      illegal_q    <= 1'b0;
      misaligned_q <= 1'b0;
    end else begin
      if (bus.PC_Write) begin
        pc_q <= {bus.PC_Next[31:2], 2'b00};
        if (bus.PC_Next[1:0] != 2'b00) begin
          misaligned_q <= 1'b1;
        end
      end
      if (bus.Ir_Write) begin
        instr_q   <= bus.Read_Data;
        old_pc_q  <= pc_q;
        illegal_q <= opcode_illegal(bus.Read_Data[6:0]);
      end
    end
  end

  // Memory-data register: captures every cycle for the one-cycle load path.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      data_q <= '0;
      adr_q  <= '0;
    end else begin
      data_q <= bus.Read_Data;
      adr_q  <= bus.Adr_Lo;
    end
  end

`ifdef PERF_CNT_EN
  logic [63:0] cycle_q, instret_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cycle_q   <= '0;
      instret_q <= '0;
    end else begin
      cycle_q <= cycle_q + 64'd1;
      if (bus.Ir_Write) begin
        instret_q <= instret_q + 64'd1;
      end
    end
  end

  assign bus.Cycle_Cnt   = cycle_q;
  assign bus.Instret_Cnt = instret_q;
`else
  assign bus.Cycle_Cnt   = 64'd0;
  assign bus.Instret_Cnt = 64'd0;
`endif

  assign bus.PC         = pc_q;
  assign bus.Old_PC     = old_pc_q;
  assign bus.Instr      = instr_q;
  assign bus.op         = instr_q[6:0];
  assign bus.Funct3     = instr_q[14:12];
  assign bus.Funct7b5   = instr_q[30];
  assign bus.Rs1        = instr_q[19:15];
  assign bus.Rs2        = instr_q[24:20];
  assign bus.Rd         = instr_q[11:7];
  assign bus.Illegal    = illegal_q;
  assign bus.Misaligned = misaligned_q;

  load_extend u_load_extend (
    .data_i      (data_q),
    .adr_i       (adr_q),
    .funct3_i    (instr_q[14:12]),
    .load_data_o (bus.Load_Data)
  );

endmodule

// File: tb/tb_fetch_decode_regs.sv
// Self-checking bench for fetch_decode_regs against a behavioural reference model.
module tb_fetch_decode_regs;

  logic clk;
  logic reset;

  fetch_decode_regs_if bus ();

  fetch_decode_regs dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp;
  int n_bad;

  // Reference state
  logic [31:0]     m_pc, m_old_pc, m_instr, m_data;
  logic [1:0]      m_adr;
  logic            m_ill, m_mis;
  longint unsigned m_cyc, m_ret;

  int legal_ops [10] = '{'h03, 'h13, 'h17, 'h23, 'h33, 'h37, 'h63, 'h67, 'h6F, 'h73};

  function automatic logic ref_illegal(logic [6:0] op);
    for (int i = 0; i < 10; i++) begin
      if (int'(op) == legal_ops[i]) return 1'b0;
    end
    return 1'b1;
  endfunction

  function automatic logic [31:0] ref_load(logic [31:0] data, logic [1:0] adr, logic [2:0] f3);
    logic [31:0] b, h;
    b = (data >> (int'(adr) * 8)) & 32'hFF;
    h = (data >> (int'(adr[1]) * 16)) & 32'hFFFF;
    case (f3)
      3'd0:    return (b >= 32'd128) ? b - 32'd256 : b;
      3'd1:    return (h >= 32'd32768) ? h - 32'd65536 : h;
      3'd4:    return b;
      3'd5:    return h;
      default: return data;
    endcase
  endfunction

  function automatic logic [63:0] exp_cyc();
`ifdef PERF_CNT_EN
    return m_cyc;
`else
    return 64'd0;
`endif
  endfunction

  function automatic logic [63:0] exp_ret();
`ifdef PERF_CNT_EN
    return m_ret;
`else
    return 64'd0;
`endif
  endfunction

  task automatic model_reset();
    m_pc = 32'h0; m_old_pc = 32'h0; m_instr = 32'h13; m_data = 32'h0; m_adr = 2'd0;
    m_ill = 1'b0; m_mis = 1'b0; m_cyc = 0; m_ret = 0;
  endtask

  task automatic idle_inputs();
    bus.PC_Write = 1'b0; bus.Ir_Write = 1'b0; bus.PC_Next = 32'h0;
    bus.Read_Data = 32'h0; bus.Adr_Lo = 2'd0;
  endtask

  // One clock edge; the model advances on pre-edge inputs, outputs sampled 1ns later.
  task automatic tick();
    @(posedge clk);
    if (reset) begin
      m_cyc++;
      if (bus.Ir_Write) begin
        m_ret++;
        m_old_pc = m_pc;
        m_instr  = bus.Read_Data;
        m_ill    = ref_illegal(bus.Read_Data[6:0]);
      end
      if (bus.PC_Write) begin
        m_pc = bus.PC_Next & 32'hFFFF_FFFC;
        if (bus.PC_Next % 4 != 0) m_mis = 1'b1;
      end
      m_data = bus.Read_Data;
      m_adr  = bus.Adr_Lo;
    end
    #1;
  endtask

  task automatic pulse_reset();
    @(negedge clk);
    reset = 1'b0;
    model_reset();
    #1;
    @(negedge clk);
    reset = 1'b1;
  endtask

  task automatic test_reset();
    // Power-on state
    if (bus.PC !== 32'h0 || bus.Instr !== 32'h13 || bus.op !== 7'h13) begin
      $display("FAIL por_state: PC=%h Instr=%h op=%h want 0/00000013/13", bus.PC, bus.Instr,
               bus.op);
      n_bad++;
    end
    n_cmp++;
    // Move PC to 0x40, then assert reset between edges.
    bus.PC_Write = 1'b1; bus.PC_Next = 32'h40; bus.Ir_Write = 1'b1; bus.Read_Data = 32'h0000_0033;
    tick();
    idle_inputs();
    if (bus.PC !== 32'h40) begin
      $display("FAIL reset_pre_pc: got %h want 00000040", bus.PC); n_bad++;
    end
    n_cmp++;
    #2;
    reset = 1'b0;
    model_reset();
    #1;
    if (bus.PC !== 32'h0 || bus.Old_PC !== 32'h0 || bus.Instr !== 32'h13 || bus.op !== 7'h13) begin
      $display("FAIL async_reset_regs: PC=%h Old_PC=%h Instr=%h op=%h", bus.PC, bus.Old_PC,
               bus.Instr, bus.op);
      n_bad++;
    end
    n_cmp++;
    if (bus.Illegal !== 1'b0 || bus.Misaligned !== 1'b0 || bus.Load_Data !== 32'h0 ||
        bus.Cycle_Cnt !== 64'd0 || bus.Instret_Cnt !== 64'd0) begin
      $display("FAIL async_reset_flags: Ill=%b Mis=%b LD=%h cyc=%0d ret=%0d want all zero",
               bus.Illegal, bus.Misaligned, bus.Load_Data, bus.Cycle_Cnt, bus.Instret_Cnt);
      n_bad++;
    end
    n_cmp++;
    @(negedge clk);
    reset = 1'b1;
  endtask

  task automatic test_fetch();
    bus.PC_Write = 1'b1; bus.PC_Next = 32'h100;
    tick();
    bus.PC_Next = 32'h104; bus.Ir_Write = 1'b1; bus.Read_Data = 32'h00A3_0333;
    tick();
    idle_inputs();
    if (bus.PC !== m_pc || bus.Old_PC !== m_old_pc || bus.PC !== 32'h104) begin
      $display("FAIL fetch_pc: PC=%h Old_PC=%h want %h/%h", bus.PC, bus.Old_PC, m_pc, m_old_pc);
      n_bad++;
    end
    n_cmp++;
    if (bus.op !== 7'h33 || bus.Rd !== 5'd6 || bus.Rs1 !== 5'd6 || bus.Rs2 !== 5'd10 ||
        bus.Illegal !== 1'b0) begin
      $display("FAIL fetch_fields: op=%h rd=%0d rs1=%0d rs2=%0d ill=%b want 33/6/6/10/0",
               bus.op, bus.Rd, bus.Rs1, bus.Rs2, bus.Illegal);
      n_bad++;
    end
    n_cmp++;
  endtask

  task automatic test_loads();
    logic [31:0] instrs [4] = '{32'h0000_0003, 32'h0000_0003, 32'h0000_0003, 32'h0000_5003};
    logic [1:0]  adrs   [4] = '{2'd1, 2'd2, 2'd3, 2'd2};
    for (int i = 0; i < 4; i++) begin
      bus.Ir_Write = 1'b1; bus.Read_Data = instrs[i];
      tick();
      bus.Ir_Write = 1'b0; bus.Read_Data = 32'h80FF_7F01; bus.Adr_Lo = adrs[i];
      tick();
      idle_inputs();
      if (bus.Load_Data !== ref_load(m_data, m_adr, m_instr[14:12])) begin
        $display("FAIL load_ext[%0d]: got %h want %h", i, bus.Load_Data,
                 ref_load(m_data, m_adr, m_instr[14:12]));
        n_bad++;
      end
      n_cmp++;
    end
  endtask

  task automatic test_illegal_misaligned();
    bus.Ir_Write = 1'b1; bus.Read_Data = 32'h0000_007F;
    tick();
    idle_inputs();
    if (bus.Illegal !== 1'b1) begin
      $display("FAIL illegal_7f: got %b want 1", bus.Illegal); n_bad++;
    end
    n_cmp++;
    bus.PC_Write = 1'b1; bus.PC_Next = 32'h206;
    tick();
    if (bus.PC !== 32'h204 || bus.Misaligned !== 1'b1) begin
      $display("FAIL misaligned_206: PC=%h Mis=%b want 00000204/1", bus.PC, bus.Misaligned);
      n_bad++;
    end
    n_cmp++;
    for (int i = 0; i < 3; i++) begin
      bus.PC_Next = 32'h300 + 32'(i * 4);
      tick();
    end
    idle_inputs();
    if (bus.Misaligned !== 1'b1 || bus.PC !== m_pc) begin
      $display("FAIL misaligned_sticky: Mis=%b PC=%h want 1/%h", bus.Misaligned, bus.PC, m_pc);
      n_bad++;
    end
    n_cmp++;
  endtask

  task automatic test_hold();
    logic [31:0] pc0, old0, ir0;
    pc0 = m_pc; old0 = m_old_pc; ir0 = m_instr;
    for (int i = 0; i < 10; i++) begin
      bus.Read_Data = $urandom; bus.Adr_Lo = 2'($urandom_range(3));
      tick();
      if (bus.PC !== pc0 || bus.Old_PC !== old0 || bus.Instr !== ir0) begin
        $display("FAIL hold_regs[%0d]: PC=%h Old=%h IR=%h want %h/%h/%h", i, bus.PC,
                 bus.Old_PC, bus.Instr, pc0, old0, ir0);
        n_bad++;
      end
      n_cmp++;
      if (bus.Load_Data !== ref_load(m_data, m_adr, m_instr[14:12])) begin
        $display("FAIL hold_data[%0d]: got %h want %h", i, bus.Load_Data,
                 ref_load(m_data, m_adr, m_instr[14:12]));
        n_bad++;
      end
      n_cmp++;
    end
    idle_inputs();
  endtask

  task automatic test_random();
    for (int i = 0; i < 200; i++) begin
      bus.PC_Write = 1'($urandom);
      bus.Ir_Write = 1'($urandom);
      bus.PC_Next  = ($urandom_range(7) == 0) ? $urandom : ($urandom & 32'hFFFF_FFFC);
      bus.Read_Data = $urandom;
      if (bus.Ir_Write && $urandom_range(3) != 0)
        bus.Read_Data = (bus.Read_Data & 32'hFFFF_FF80) | 32'(legal_ops[$urandom_range(9)]);
      bus.Adr_Lo = 2'($urandom_range(3));
      if (i == 100) pulse_reset();
      tick();
      if (bus.PC !== m_pc || bus.Old_PC !== m_old_pc || bus.Instr !== m_instr) begin
        $display("FAIL rand_regs[%0d]: PC=%h Old=%h IR=%h want %h/%h/%h", i, bus.PC,
                 bus.Old_PC, bus.Instr, m_pc, m_old_pc, m_instr);
        n_bad++;
      end
      n_cmp++;
      if (bus.op !== 7'(m_instr) || bus.Funct3 !== 3'(m_instr >> 12) ||
          bus.Funct7b5 !== 1'(m_instr >> 30) || bus.Rs1 !== 5'(m_instr >> 15) ||
          bus.Rs2 !== 5'(m_instr >> 20) || bus.Rd !== 5'(m_instr >> 7)) begin
        $display("FAIL rand_fields[%0d]: op=%h f3=%h f7b5=%b rs1=%0d rs2=%0d rd=%0d IR=%h", i,
                 bus.op, bus.Funct3, bus.Funct7b5, bus.Rs1, bus.Rs2, bus.Rd, m_instr);
        n_bad++;
      end
      n_cmp++;
      if (bus.Illegal !== m_ill || bus.Misaligned !== m_mis ||
          bus.Load_Data !== ref_load(m_data, m_adr, m_instr[14:12])) begin
        $display("FAIL rand_misc[%0d]: Ill=%b Mis=%b LD=%h want %b/%b/%h", i, bus.Illegal,
                 bus.Misaligned, bus.Load_Data, m_ill, m_mis,
                 ref_load(m_data, m_adr, m_instr[14:12]));
        n_bad++;
      end
      n_cmp++;
      if (bus.Cycle_Cnt !== exp_cyc() || bus.Instret_Cnt !== exp_ret()) begin
        $display("FAIL rand_cnt[%0d]: cyc=%0d ret=%0d want %0d/%0d", i, bus.Cycle_Cnt,
                 bus.Instret_Cnt, exp_cyc(), exp_ret());
        n_bad++;
      end
      n_cmp++;
    end
    idle_inputs();
  endtask

  task automatic test_counters();
    logic [63:0] want_cyc, want_ret;
    pulse_reset();
    for (int i = 0; i < 20; i++) begin
      bus.Ir_Write = (i % 4 == 0);
      bus.Read_Data = 32'h0000_0013;
      tick();
    end
    idle_inputs();
`ifdef PERF_CNT_EN
    want_cyc = 64'd20; want_ret = 64'd5;
`else
    want_cyc = 64'd0;  want_ret = 64'd0;
`endif
    if (bus.Cycle_Cnt !== want_cyc || bus.Instret_Cnt !== want_ret) begin
      $display("FAIL counters_20: cyc=%0d ret=%0d want %0d/%0d", bus.Cycle_Cnt,
               bus.Instret_Cnt, want_cyc, want_ret);
      n_bad++;
    end
    n_cmp++;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    n_cmp = 0;
    n_bad = 0;
    reset = 1'b0;
    idle_inputs();
    model_reset();
    #3;
    @(negedge clk);
    reset = 1'b1;
    test_reset();
    test_fetch();
    test_loads();
    test_illegal_misaligned();
    test_hold();
    test_random();
    test_counters();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
